// File: rtl/zone_alarm_ctrl.sv
// zone_alarm_ctrl: intrusion alarm FSM with exit/entry delays, zone bypass and wrong-key lockout
module zone_alarm_ctrl #(
  parameter int N_ZONES   = 4,
  parameter int CNT_W     = 18,
  parameter int EXIT_DLY  = 15000,
  parameter int ENTRY_DLY = 15000,
  parameter int SIREN_MAX = 60000,
  parameter int MAX_ERR   = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_ZONES-1:0] SENSOR_IN,
  input  logic [N_ZONES-1:0] ZONE_DELAYED,
  input  logic               KEY_OK,
  input  logic               KEY_ERR,
  output logic               SIREN_OUT,
  output logic [2:0]         STATE_OUT,
  output logic               ARMED_OUT,
  output logic [N_ZONES-1:0] ZONE_LATCH
);
  typedef enum logic [2:0] {DISARMED = 3'd0, EXIT = 3'd1, ARMED = 3'd2, ENTRY = 3'd3, ALARM = 3'd4} state_t;
  state_t state, nst;
  logic [CNT_W-1:0] cnt, ncnt;
  logic [2:0] err, nerr, err_inc;
  logic [N_ZONES-1:0] s1, s_zone, mask, nmask, nlatch, act, inst_v, dly_v;
  logic inst, dly, lockout;
  assign act = s_zone & ~mask;
  assign inst_v = act & ~ZONE_DELAYED;
  assign dly_v = act & ZONE_DELAYED;
  assign inst = |inst_v;
  assign dly = |dly_v;
  assign err_inc = (err == 3'd7) ? err : err + 3'd1;
  assign lockout = KEY_ERR && (err_inc >= 3'(MAX_ERR));
  assign STATE_OUT = state;
  always_comb begin
    nst = DISARMED;
    ncnt = cnt;
    nerr = err;
    nmask = mask;
    nlatch = ZONE_LATCH;
    case (state)
      DISARMED: begin
        nst = KEY_OK ? EXIT : DISARMED;
        if (KEY_OK) begin
          ncnt = CNT_W'(EXIT_DLY - 1);
          nlatch = '0;
          nmask = '0;
        end
      end
      EXIT: begin
        nst = KEY_OK ? DISARMED : (cnt == '0) ? ARMED : EXIT;
        ncnt = (cnt == '0) ? cnt : cnt - 1'b1;
      end
      ARMED: begin
        if (KEY_OK) nst = DISARMED;
        else begin
          if (KEY_ERR) nerr = err_inc;
          nlatch = lockout ? ZONE_LATCH : inst ? ZONE_LATCH | inst_v : dly ? ZONE_LATCH | dly_v : ZONE_LATCH;
          nst = (lockout || inst) ? ALARM : dly ? ENTRY : ARMED;
          if (!lockout && !inst && dly) ncnt = CNT_W'(ENTRY_DLY - 1);
        end
      end
      ENTRY: begin
        if (KEY_OK) nst = DISARMED;
        else begin
          if (KEY_ERR) nerr = err_inc;
          if (!lockout && inst) nlatch = ZONE_LATCH | inst_v;
          nst = (lockout || inst || cnt == '0) ? ALARM : ENTRY;
          ncnt = cnt - 1'b1;
        end
      end
      ALARM: begin
        nst = KEY_OK ? DISARMED : (cnt == '0) ? ARMED : ALARM;
        ncnt = (cnt == '0) ? cnt : cnt - 1'b1;
      end
      default: nst = DISARMED;
    endcase
    // every way into ALARM starts the siren timer and bypasses the offending zones
    if (nst == ALARM && state != ALARM) begin
      ncnt = CNT_W'(SIREN_MAX - 1);
      nerr = '0;
      nmask = mask | nlatch;
    end
    if (KEY_OK) nerr = '0;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1 <= '0;
      s_zone <= '0;
      state <= DISARMED;
      cnt <= '0;
      err <= '0;
      mask <= '0;
      ZONE_LATCH <= '0;
      SIREN_OUT <= 1'b0;
      ARMED_OUT <= 1'b0;
    end else begin
      s1 <= SENSOR_IN;
      s_zone <= s1;
      state <= nst;
      cnt <= ncnt;
      err <= nerr;
      mask <= nmask;
      ZONE_LATCH <= nlatch;
      SIREN_OUT <= (nst == ALARM);
      ARMED_OUT <= (nst != DISARMED);
    end
  end
endmodule

// File: doc/zone_alarm_ctrl.md
ZONE_ALARM_CTRL -- requirements
Module: zone_alarm_ctrl

Interface
REQ-001 The block SHALL have parameter N_ZONES, default 4, giving the number of sensor zones (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 18, giving the delay counter width.
REQ-003 The block SHALL have parameter EXIT_DLY, default 15000, giving the exit-delay length in CLK cycles (1..2^CNT_W-1).
REQ-004 The block SHALL have parameter ENTRY_DLY, default 15000, giving the entry-delay length in CLK cycles (1..2^CNT_W-1).
REQ-005 The block SHALL have parameter SIREN_MAX, default 60000, giving the siren-on length in CLK cycles before auto re-arm (1..2^CNT_W-1).
REQ-006 The block SHALL have parameter MAX_ERR, default 3, giving the number of consecutive wrong keys that triggers alarm (1..7).
REQ-007 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port SENSOR_IN, input, N_ZONES bits: raw asynchronous zone sensors, 1 = tripped.
REQ-010 The block SHALL have port ZONE_DELAYED, input, N_ZONES bits: static zone mode, 1 = delayed (door), 0 = instant (window).
REQ-011 The block SHALL have port KEY_OK, input, 1 bit: single-cycle synchronous pulse, correct code entered.
REQ-012 The block SHALL have port KEY_ERR, input, 1 bit: single-cycle synchronous pulse, wrong code entered.
REQ-013 The block SHALL have port SIREN_OUT, output, 1 bit: registered siren drive.
REQ-014 The block SHALL have port STATE_OUT, output, 3 bits: current state encoding.
REQ-015 The block SHALL have port ARMED_OUT, output, 1 bit: 1 whenever the state is not DISARMED.
REQ-016 The block SHALL have port ZONE_LATCH, output, N_ZONES bits: zones that caused ENTRY or ALARM since the last arming.

Function
REQ-017 SENSOR_IN SHALL pass through a 2-flop synchronizer per bit; the synchronized value (s_zone) feeds all logic, giving 2 cycles of sensor latency.
REQ-018 The state encoding SHALL be DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4; codes 5-7 SHALL go to DISARMED on the next edge.
REQ-019 Active zones SHALL be act = s_zone & ~ZONE_LATCH_mask, where the mask is set per zone on its ALARM latch and cleared on leaving DISARMED.
REQ-020 Instant hits SHALL be inst = |(act & ~ZONE_DELAYED), and delayed hits SHALL be dly = |(act & ZONE_DELAYED).
REQ-021 KEY_OK SHALL have highest priority; KEY_OK together with KEY_ERR SHALL be treated as KEY_OK only.
REQ-022 In DISARMED, KEY_OK SHALL go to EXIT, load the counter with EXIT_DLY-1, and clear ZONE_LATCH, the mask and the error count; KEY_ERR and sensors SHALL be ignored.
REQ-023 In EXIT, KEY_OK SHALL go to DISARMED; when the counter is 0 the block SHALL go to ARMED; otherwise the counter SHALL decrement; sensors SHALL be ignored; the state therefore lasts EXIT_DLY cycles.
REQ-024 In ARMED, KEY_OK SHALL go to DISARMED; otherwise inst SHALL go to ALARM; otherwise dly SHALL go to ENTRY with the counter loaded with ENTRY_DLY-1; each triggering zone SHALL be OR'd into ZONE_LATCH.
REQ-025 In ENTRY, KEY_OK SHALL go to DISARMED; otherwise inst SHALL go to ALARM at once; otherwise a counter at 0 SHALL go to ALARM; otherwise the counter SHALL decrement; the state lasts ENTRY_DLY cycles unless pre-empted.
REQ-026 In ARMED and ENTRY, KEY_ERR SHALL increment the error count (saturating); reaching MAX_ERR SHALL go to ALARM on the same edge, and this takes priority over sensor events.
REQ-027 On entering ALARM, the counter SHALL load SIREN_MAX-1, the error count SHALL clear, and currently latched zones SHALL be set in the mask.
REQ-028 In ALARM, KEY_OK SHALL go to DISARMED; when the counter is 0 the block SHALL go to ARMED (auto re-arm, masked zones stay bypassed); KEY_ERR SHALL be ignored.
REQ-029 The error count SHALL clear on any KEY_OK.
REQ-030 SIREN_OUT SHALL be 1 exactly in the cycles where the registered state is ALARM.
REQ-031 STATE_OUT SHALL be the registered state, and ARMED_OUT SHALL be registered.
REQ-032 ZONE_LATCH SHALL hold its value through DISARMED for inspection.

Reset
REQ-033 While RST=1, state, counter, error count, mask, ZONE_LATCH and synchronizers SHALL be 0, and SIREN_OUT=0, STATE_OUT=0, ARMED_OUT=0, independent of CLK.
REQ-034 On RST asserted mid-operation (any state, any counter value), outputs SHALL clear immediately, and the first edge after release SHALL evaluate from DISARMED.

Verification (N_ZONES=4, EXIT_DLY=4, ENTRY_DLY=5, SIREN_MAX=8, MAX_ERR=3, ZONE_DELAYED=4'b0001)
REQ-035 Arm: KEY_OK in DISARMED -> STATE_OUT=1 for exactly 4 cycles, then 2, ARMED_OUT=1 throughout.
REQ-036 Entry: ARMED, SENSOR_IN[0] pulses -> ENTRY 2 cycles later, ZONE_LATCH=4'b0001; no key -> ALARM after 5 cycles, SIREN_OUT=1 for 8 cycles, then ARMED with zone 0 bypassed (SENSOR_IN[0]=1 causes no retrigger).
REQ-037 Instant pre-empt: ENTRY with counter=3, SENSOR_IN[2]=1 -> ALARM 2 cycles later, ZONE_LATCH=4'b0101.
REQ-038 Wrong keys: ARMED, KEY_ERR x3 -> ALARM on the third pulse's edge; KEY_ERR+KEY_OK in the same cycle -> DISARMED, error count 0.
REQ-039 Reset: RST pulsed during ALARM with counter=5 -> SIREN_OUT=0 and STATE_OUT=0 without a clock edge; after release, KEY_OK -> EXIT.
